// File: rtl/key_pkg.sv
// Shared types and default timing for the per-button key event stage.
// Defaults are also referenced by the timer control block.
package key_pkg;

  typedef enum logic [1:0] {
    KS_LOCK,
    KS_IDLE,
    KS_PRESSED,
    KS_REPEAT
  } key_state_t;

  // 1 s long-press and 200 ms auto-repeat at a 50 MHz clk
  localparam int KEY_LONG_CYCLES   = 50_000_000;
  localparam int KEY_REPEAT_CYCLES = 10_000_000;

  // Width needed to hold the larger of the two hold thresholds
  function automatic int key_cnt_w(input int long_cycles, input int repeat_cycles);
    int max_c;
    max_c = (long_cycles > repeat_cycles) ? long_cycles : repeat_cycles;
    return $clog2(max_c + 1);
  endfunction

endpackage

// File: rtl/key_event_if.sv
// Key level in, registered event pulses out; master is the key_event side.
// release/repeat are SV keywords, hence the _evt suffix on those two pulses.
interface key_event_if;

  logic key_press;
  logic press;
  logic release_evt;
  logic long_press;
  logic repeat_evt;
  logic held;

  modport master (
    input  key_press,
    output press,
    output release_evt,
    output long_press,
    output repeat_evt,
    output held
  );

  modport slave (
    output key_press,
    input  press,
    input  release_evt,
    input  long_press,
    input  repeat_evt,
    input  held
  );

endinterface

// File: rtl/key_event.sv
// Turns a debounced key level into press/release/long-press/repeat pulses plus a held level.
// All outputs registered; a key already down at reset is ignored until it is let go.
module key_event
  import key_pkg::*;
#(
  parameter int LONG_CYCLES   = KEY_LONG_CYCLES,
  parameter int REPEAT_CYCLES = KEY_REPEAT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  key_event_if.master kif
);

  localparam int CNT_W = key_cnt_w(LONG_CYCLES, REPEAT_CYCLES);
  localparam int REP_LAST = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_M1  = CNT_W'(REP_LAST);
  localparam bit REP_EN = (REPEAT_CYCLES != 0);

  if (LONG_CYCLES < 2) begin : g_long_chk
    $fatal(1, "key_event: LONG_CYCLES must be >= 2");
  end

  key_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             press_q;
  logic             release_q;
  logic             long_q;
  logic             repeat_q;
  logic             held_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= KS_LOCK;
      cnt       <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      case (state)
        KS_LOCK: begin
          if (!kif.key_press) begin
            state <= KS_IDLE;
          end
        end
        KS_IDLE: begin
          if (kif.key_press) begin
            press_q <= 1'b1;
            held_q  <= 1'b1;
            cnt     <= '0;
            state   <= KS_PRESSED;
          end
        end
        KS_PRESSED: begin
          // Release wins over a threshold hit on the same edge
          if (!kif.key_press) begin
            release_q <= 1'b1;
            held_q    <= 1'b0;
            state     <= KS_IDLE;
          end else if (cnt == LONG_M1) begin
            long_q <= 1'b1;
            cnt    <= '0;
            state  <= KS_REPEAT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        KS_REPEAT: begin
          if (!kif.key_press) begin
            release_q <= 1'b1;
            held_q    <= 1'b0;
            state     <= KS_IDLE;
          end else if (REP_EN && cnt == REP_M1) begin
            repeat_q <= 1'b1;
            cnt      <= '0;
          end else if (REP_EN) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= KS_LOCK;
          held_q <= 1'b0;
        end
      endcase
    end
  end

  assign kif.press       = press_q;
  assign kif.release_evt = release_q;
  assign kif.long_press  = long_q;
  assign kif.repeat_evt  = repeat_q;
  assign kif.held        = held_q;

endmodule

// File: tb/tb_key_event.sv
// Drives one key sequence into two key_event instances (repeat on / repeat off)
// and checks every edge against a time-since-press expectation queue.
module tb_key_event;

  localparam int L  = 8;
  localparam int RA = 4;
  localparam int RB = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_event_if ka();
  key_event_if kb();

  key_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(RA)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (ka.master)
  );

  key_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(RB)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kb.master)
  );

  typedef struct {
    logic lock;
    logic held;
    int   k;
  } m_t;

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
  } exp_t;

  exp_t sb[$];
  m_t   ma = '{lock: 1'b1, held: 1'b0, k: 0};
  m_t   mb = '{lock: 1'b1, held: 1'b0, k: 0};
  int   checks = 0;
  int   errors = 0;
  int   press_b = 0;
  int   long_b = 0;
  int   rep_b = 0;

  // Bit order: press, release, long_press, repeat, held
  function automatic logic [4:0] obs_a();
    return {ka.press, ka.release_evt, ka.long_press, ka.repeat_evt, ka.held};
  endfunction

  function automatic logic [4:0] obs_b();
    return {kb.press, kb.release_evt, kb.long_press, kb.repeat_evt, kb.held};
  endfunction

  // Expected outputs from edges elapsed since the accepted press
  task automatic model(input int lc, input int rc, input logic rst, input logic key,
                       inout m_t m, output logic [4:0] e);
    e = 5'b00000;
    if (rst) begin
      m.lock = 1'b1;
      m.held = 1'b0;
      m.k    = 0;
    end else if (m.lock) begin
      if (!key) m.lock = 1'b0;
    end else if (!m.held) begin
      if (key) begin
        e      = 5'b10001;
        m.held = 1'b1;
        m.k    = 0;
      end
    end else if (!key) begin
      e      = 5'b01000;
      m.held = 1'b0;
    end else begin
      m.k  = m.k + 1;
      e[0] = 1'b1;
      if (m.k == lc) e[2] = 1'b1;
      else if (rc != 0 && m.k > lc && ((m.k - lc) % rc) == 0) e[1] = 1'b1;
    end
  endtask

  task automatic step(input logic rst, input logic key, input string tag);
    exp_t e;
    @(negedge clk);
    rst_n        = ~rst;
    ka.key_press = key;
    kb.key_press = key;
    model(L, RA, rst, key, ma, e.a);
    model(L, RB, rst, key, mb, e.b);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (obs_a() === e.a) else begin
      errors++;
      $error("FAIL %s[rep4] observed %b expected %b", tag, obs_a(), e.a);
    end
    checks++;
    assert (obs_b() === e.b) else begin
      errors++;
      $error("FAIL %s[rep0] observed %b expected %b", tag, obs_b(), e.b);
    end
    if (kb.press === 1'b1)      press_b++;
    if (kb.long_press === 1'b1) long_b++;
    if (kb.repeat_evt === 1'b1) rep_b++;
  endtask

  task automatic run(input logic rst, input logic key, input int n, input string tag);
    for (int i = 0; i < n; i++) step(rst, key, tag);
  endtask

  initial begin
    ka.key_press = 1'b0;
    kb.key_press = 1'b0;

    // Clean reset, press, long hold with repeats, release
    run(1'b1, 1'b0, 3, "reset");
    run(1'b0, 1'b0, 9, "idle");
    run(1'b0, 1'b1, 21, "hold");
    run(1'b0, 1'b0, 3, "hold_rel");

    // Release exactly on the long-press edge
    run(1'b0, 1'b1, 8, "thr_long");
    step(1'b0, 1'b0, "thr_long_rel");
    run(1'b0, 1'b0, 2, "thr_long_idle");

    // Release exactly on the first repeat edge
    run(1'b0, 1'b1, 12, "thr_rep");
    step(1'b0, 1'b0, "thr_rep_rel");
    run(1'b0, 1'b0, 2, "thr_rep_idle");

    // Key held through reset must be ignored until let go
    run(1'b1, 1'b1, 3, "rst_keydown");
    run(1'b0, 1'b1, 5, "lock");
    run(1'b0, 1'b0, 2, "unlock");
    run(1'b0, 1'b1, 3, "repress");
    run(1'b0, 1'b0, 2, "repress_rel");

    // Reset while auto-repeating: no release for the interrupted press
    run(1'b0, 1'b1, 11, "to_rep");
    run(1'b1, 1'b1, 2, "rst_mid");
    run(1'b0, 1'b1, 3, "lock2");
    run(1'b0, 1'b0, 2, "no_rel");
    run(1'b0, 1'b1, 2, "press3");
    step(1'b0, 1'b0, "press3_rel");

    // 1-0-1 toggle: release then press, counter restarts
    run(1'b0, 1'b1, 3, "fast");
    step(1'b0, 1'b0, "fast_rel");
    run(1'b0, 1'b1, 10, "fast_press");
    run(1'b0, 1'b0, 2, "fast_idle");

    checks++;
    assert (press_b === 8) else begin
      errors++;
      $error("FAIL press_count[rep0] observed %0d expected 8", press_b);
    end
    checks++;
    assert (long_b === 4) else begin
      errors++;
      $error("FAIL long_count[rep0] observed %0d expected 4", long_b);
    end
    checks++;
    assert (rep_b === 0) else begin
      errors++;
      $error("FAIL repeat_count[rep0] observed %0d expected 0", rep_b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event.md
Name: key_event

Overview:
- Consumes the debounced, active-high `key_press` level from the debouncer stage.
- Converts it into single-cycle event pulses for the timer control logic: press, release, long-press and auto-repeat.
- Also provides a `held` level output.
- One instance per button. Sits between the debouncer and the timer's set/start/stop control FSM.

Parameters:
LONG_CYCLES, 50_000_000, clk cycles from press pulse to long_press pulse (1 s at 50 MHz); legal range >= 2
REPEAT_CYCLES, 10_000_000, clk cycles between auto-repeat pulses after long_press; 0 disables repeat
CNT_W, $clog2(max(LONG_CYCLES, REPEAT_CYCLES)+1), hold-counter width (derived; not overridden)

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  synchronous reset, active-low
key_press  input  1  debounced key level, 1 = pressed; already synchronous to clk
press  output  1  1-cycle pulse on press acceptance
release  output  1  1-cycle pulse on release of an accepted press
long_press  output  1  1-cycle pulse when hold reaches LONG_CYCLES
repeat  output  1  1-cycle pulse every REPEAT_CYCLES after long_press while held
held  output  1  level; 1 while an accepted press is in progress

Behaviour:
- Interface: one clock `clk`. Reset `rst_n` is synchronous and active-low.
- All outputs are registered. No combinational path from `key_press` to any output.
- Reset (sampled rst_n=0):
  - state=LOCK, cnt=0.
  - press, release, long_press, repeat and held all = 0 at the next edge.
- States:
  - LOCK:
    - key_press=1: stay in LOCK. No events are generated.
    - key_press=0: go to IDLE.
    - A key already down at reset or power-up therefore never produces press or release.
  - IDLE:
    - key_press=1 at edge N: press=1 and held=1 from edge N; cnt=0; go to PRESSED.
  - PRESSED, each edge:
    - key_press=0: release=1, held=0, go to IDLE.
    - Else if cnt==LONG_CYCLES-1: long_press=1, cnt=0, go to REPEAT.
    - Else cnt++.
    - Net effect: long_press is asserted exactly LONG_CYCLES edges after press (edge N+LONG_CYCLES).
  - REPEAT, each edge:
    - key_press=0: release=1, held=0, go to IDLE.
    - Else if REPEAT_CYCLES!=0 and cnt==REPEAT_CYCLES-1: repeat=1, cnt=0.
    - Else if REPEAT_CYCLES!=0: cnt++.
    - If REPEAT_CYCLES==0: cnt holds 0 and no repeat pulse is generated.
    - Repeats occur at edges N+L+R, N+L+2R, ... where L=LONG_CYCLES and R=REPEAT_CYCLES.
- Pulse rules:
  - Each pulse output is high for exactly one cycle and defaults to 0 every cycle it is not set.
  - At most one of press, release, long_press and repeat is high in any cycle.
- Priority: release beats long_press and repeat in the same cycle. If key_press falls on the threshold edge, only release fires.
- Fast re-press: key_press 1→0→1 on consecutive edges gives release, then press on the next edge; counter restarts from 0.
- Counter:
  - Unsigned, CNT_W bits.
  - Compared with == against the parameter minus 1, truncated to CNT_W.
  - Never wraps, because it is cleared at each threshold.
- Reset mid-hold:
  - Any pulse in flight is dropped and the block enters LOCK.
  - No release is emitted for the interrupted press.
- held:
  - 1 in PRESSED and REPEAT.
  - 0 in LOCK and IDLE, with the registered timing given above.
- Elaboration:
  - LONG_CYCLES < 2 is a fatal assertion.
  - REPEAT_CYCLES == 1 is legal and gives a repeat pulse on every edge after long_press.

Decomposition:
- Package key_pkg:
  - typedef enum logic [1:0] key_state_t {KS_LOCK, KS_IDLE, KS_PRESSED, KS_REPEAT}.
  - Default constants KEY_LONG_CYCLES and KEY_REPEAT_CYCLES, shared with the timer control block.
- No sub-module. The FSM and the single counter live in key_event.
- The debouncer → key_event pairing is instantiated per button by the enclosing input wrapper, not inside this block.

Test Plan (LONG_CYCLES=8, REPEAT_CYCLES=4 unless stated):
- Reset with key_press=0, release rst_n, raise key_press at edge 10 -> press=1 at edge 10 only, held=1 from edge 10; no other pulses.
- Hold key_press=1 for 20 edges from edge 10 -> long_press at edge 18; repeat at edges 22, 26, 30 (if still held); release on the first edge key_press is sampled 0; held falls on that same edge.
- Release on the threshold edge (key_press=0 sampled at edge 18) -> release=1 at 18, long_press never asserted; same check for the repeat edge 22 after entering REPEAT.
- key_press=1 throughout reset and for 5 edges after rst_n=1, then low, then high -> no pulses until the second rise, which gives press on that edge.
- Assert rst_n=0 while in REPEAT -> all outputs 0 next edge; no release when the key later falls; next rise gives a normal press.
- REPEAT_CYCLES=0, hold 30 edges -> exactly one press and one long_press, zero repeat pulses, then one release; a 1-0-1 key toggle gives release then press on consecutive edges.
